pe_row_conv1d: RTL

//  Parametrised 1-D convolution PE row; generalises the fixed 16-PE row.
//  - Runtime kernel length K (1..NUM_PE), signed operands, explicit valid/start/last framing.
//  - Two-stage multiply/add pipeline; weights can be reused across activation rows.
//  - Sits between the weight/activation SRAM readers and the psum accumulation buffer.

---
 rtl/pe_row_conv1d.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pe_row_conv1d.sv
// pe_row_conv1d: 1-D convolution PE row with runtime kernel length, weight reuse and a two-stage multiply/add pipeline.
// Define PE_SAT_EN to clamp o_psum to the OUT_W range and flag clipped beats on o_sat; otherwise o_psum wraps.
module pe_row_conv1d #(
    parameter int NUM_PE = 16,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 2*DATA_W,
    parameter int KLEN_W = $clog2(NUM_PE+1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              i_start,
    input  logic              i_reuse,
    input  logic [KLEN_W-1:0] i_klen,
    input  logic [DATA_W-1:0] i_f,
    input  logic              i_f_valid,
    input  logic [DATA_W-1:0] i_r,
    input  logic              i_r_valid,
    input  logic              i_last,
    output logic [OUT_W-1:0]  o_psum,
    output logic              o_valid,
    output logic              o_sat,
    output logic              o_busy,
    output logic              o_done
);
    localparam int PROD_W = 2*DATA_W;
    localparam int SUM_W  = 2*DATA_W + KLEN_W;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [KLEN_W-1:0]        klen_q, load_cnt_q, acc_cnt_q, klen_clamped;
    logic signed [DATA_W-1:0] w_q   [NUM_PE];
    logic signed [DATA_W-1:0] win_q [NUM_PE];
    logic signed [PROD_W-1:0] prod_q [NUM_PE];
    logic                     win_vld_q, prod_vld_q, sum_vld_q;
    logic [OUT_W-1:0]         psum_q;
    logic                     drain_q, done_pend_q, done_q;
    logic                     start_load, start_reuse, take_w, take_x, load_last;
    logic signed [SUM_W-1:0]  sum_full;
    logic [OUT_W-1:0]         sum_red;

    assign klen_clamped = (i_klen > KLEN_W'(NUM_PE)) ? KLEN_W'(NUM_PE) : i_klen;
    assign start_load   = i_start && !i_reuse && (i_klen != '0);
    assign start_reuse  = i_start && i_reuse && (klen_q != '0);
    assign take_w       = (state_q == LOAD) && i_f_valid;
    assign take_x       = (state_q == RUN) && i_r_valid;
    assign load_last    = take_w && (load_cnt_q == klen_q - KLEN_W'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= IDLE;
        else if (en)
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_load)
                    state_d = LOAD;
                else if (start_reuse)
                    state_d = RUN;
            end
            LOAD:    if (load_last) state_d = RUN;
            RUN:     if (take_x && i_last) state_d = DRAIN;
            DRAIN:   if (drain_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            klen_q      <= '0;
            load_cnt_q  <= '0;
            acc_cnt_q   <= '0;
            win_vld_q   <= 1'b0;
            prod_vld_q  <= 1'b0;
            sum_vld_q   <= 1'b0;
            psum_q      <= '0;
            drain_q     <= 1'b0;
            done_pend_q <= 1'b0;
            done_q      <= 1'b0;
            for (int k = 0; k < NUM_PE; k++) begin
                w_q[k]    <= '0;
                win_q[k]  <= '0;
                prod_q[k] <= '0;
            end
        end else if (en) begin
            if (state_q == IDLE && start_load) begin
                klen_q     <= klen_clamped;
                load_cnt_q <= '0;
            end
            if (take_w) begin
                for (int k = 0; k < NUM_PE; k++)
                    if (load_cnt_q == KLEN_W'(k))
                        w_q[k] <= i_f;
                load_cnt_q <= load_cnt_q + KLEN_W'(1);
            end
            // A frame always starts from an empty window, whether weights were just loaded or reused.
            if ((state_q == IDLE && start_reuse) || load_last) begin
                acc_cnt_q <= '0;
                for (int k = 0; k < NUM_PE; k++)
                    win_q[k] <= '0;
            end
            if (take_x) begin
                win_q[0] <= i_r;
                for (int k = 1; k < NUM_PE; k++)
                    win_q[k] <= win_q[k-1];
                if (acc_cnt_q != klen_q)
                    acc_cnt_q <= acc_cnt_q + KLEN_W'(1);
                win_vld_q <= (acc_cnt_q == klen_q) || (acc_cnt_q + KLEN_W'(1) == klen_q);
            end else begin
                win_vld_q <= 1'b0;
            end
            for (int k = 0; k < NUM_PE; k++)
                prod_q[k] <= (k < int'(klen_q)) ? PROD_W'(w_q[k]) * PROD_W'(win_q[k]) : '0;
            prod_vld_q  <= win_vld_q;
            sum_vld_q   <= prod_vld_q;
            psum_q      <= sum_red;
            drain_q     <= (state_q == DRAIN) ? ~drain_q : 1'b0;
            done_pend_q <= (state_q == DRAIN) && drain_q;
            done_q      <= done_pend_q;
        end
    end

    always_comb begin
        sum_full = '0;
        for (int k = 0; k < NUM_PE; k++)
            sum_full = sum_full + SUM_W'(prod_q[k]);
    end

`ifdef PE_SAT_EN
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic sat_d, sat_q;

    always_comb begin
        sum_red = sum_full[OUT_W-1:0];
        sat_d   = 1'b0;
        if (sum_full > SAT_MAX) begin
            sum_red = SAT_MAX[OUT_W-1:0];
            sat_d   = 1'b1;
        end else if (sum_full < SAT_MIN) begin
            sum_red = SAT_MIN[OUT_W-1:0];
            sat_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            sat_q <= 1'b0;
        else if (en)
            sat_q <= sat_d;
    end

    assign o_sat = sat_q && sum_vld_q && en;
`else
    logic sum_hi_unused;

    assign sum_red       = sum_full[OUT_W-1:0];
    assign sum_hi_unused = ^sum_full[SUM_W-1:OUT_W];
    assign o_sat         = 1'b0;
`endif

    assign o_psum  = psum_q;
    assign o_valid = sum_vld_q && en;
    assign o_busy  = (state_q != IDLE);
    assign o_done  = done_q;

endmodule
